// File: rtl/cmm_errman_msg_req.sv
// Error-message requester: counts pending correctable/non-fatal/fatal errors per
// class and issues one prioritised message request at a time to the transmitter.
module cmm_errman_msg_req #(
  parameter int CNT_W = 3,
  parameter int FFD   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cor_inc,
  input  logic             nfl_inc,
  input  logic             ftl_inc,
  input  logic             cor_en,
  input  logic             nfl_en,
  input  logic             ftl_en,
  input  logic             msg_ack,
  output logic             msg_req,
  output logic [1:0]       msg_code,
  output logic [CNT_W-1:0] cor_cnt,
  output logic [CNT_W-1:0] nfl_cnt,
  output logic [CNT_W-1:0] ftl_cnt,
  output logic [2:0]       cnt_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  localparam logic [1:0]       CODE_COR = 2'b00;
  localparam logic [1:0]       CODE_NFL = 2'b01;
  localparam logic [1:0]       CODE_FTL = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t     state_r;
  logic       msg_req_r;
  logic [1:0] msg_code_r;
  logic [2:0] inc_s;
  logic [2:0] en_s;
  logic [2:0] dec_s;
  logic       unused_ffd_s;

  // FFD only models register delay in some simulation flows; nothing here uses it.
  assign unused_ffd_s = (FFD != 0);

  // Class index: 0 correctable, 1 non-fatal, 2 fatal.
  assign inc_s = {ftl_inc, nfl_inc, cor_inc};
  assign en_s  = {ftl_en, nfl_en, cor_en};

  // Returns {saturation_hit, next_count}; inc at max and dec at zero both hold.
  function automatic logic [CNT_W:0] cnt_upd(input logic [CNT_W-1:0] cnt,
                                             input logic en, input logic inc,
                                             input logic dec);
    logic [CNT_W:0] res;
    if (!en) begin
      res = {1'b0, CNT_ZERO};
    end else if (inc && dec) begin
      res = {1'b0, cnt};
    end else if (inc) begin
      if (cnt == CNT_MAX) res = {1'b1, cnt};
      else                res = {1'b0, cnt + CNT_ONE};
    end else if (dec) begin
      if (cnt == CNT_ZERO) res = {1'b0, cnt};
      else                 res = {1'b0, cnt - CNT_ONE};
    end else begin
      res = {1'b0, cnt};
    end
    return res;
  endfunction

  // Acknowledge of the latched class, only meaningful while requesting.
  always_comb begin
    dec_s = 3'b000;
    if ((state_r == ST_REQ) && msg_ack) begin
      case (msg_code_r)
        CODE_COR: dec_s = 3'b001;
        CODE_NFL: dec_s = 3'b010;
        CODE_FTL: dec_s = 3'b100;
        default:  dec_s = 3'b000;
      endcase
    end else begin
      dec_s = 3'b000;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_cls
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic [CNT_W:0]   upd_s;

    assign upd_s = cnt_upd(cnt_r, en_s[g], inc_s[g], dec_s[g]);

    // Per-class pending counter with sticky saturation flag, cleared by disable.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r <= CNT_ZERO;
        ovf_r <= 1'b0;
      end else begin
        cnt_r <= upd_s[CNT_W-1:0];
        ovf_r <= en_s[g] ? (ovf_r | upd_s[CNT_W]) : 1'b0;
      end
    end
  end

  assign cor_cnt = g_cls[0].cnt_r;
  assign nfl_cnt = g_cls[1].cnt_r;
  assign ftl_cnt = g_cls[2].cnt_r;
  assign cnt_ovf = {g_cls[2].ovf_r, g_cls[1].ovf_r, g_cls[0].ovf_r};

  // Request sequencer; once in REQ it waits for the ack regardless of counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      msg_req_r  <= 1'b0;
      msg_code_r <= CODE_COR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ftl_cnt != CNT_ZERO) begin
            state_r    <= ST_REQ;
            msg_req_r  <= 1'b1;
            msg_code_r <= CODE_FTL;
          end else if (nfl_cnt != CNT_ZERO) begin
            state_r    <= ST_REQ;
            msg_req_r  <= 1'b1;
            msg_code_r <= CODE_NFL;
          end else if (cor_cnt != CNT_ZERO) begin
            state_r    <= ST_REQ;
            msg_req_r  <= 1'b1;
            msg_code_r <= CODE_COR;
          end else begin
            state_r   <= ST_IDLE;
            msg_req_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (msg_ack) begin
            state_r   <= ST_GAP;
            msg_req_r <= 1'b0;
          end else begin
            state_r   <= ST_REQ;
            msg_req_r <= 1'b1;
          end
        end
        ST_GAP: begin
          state_r   <= ST_IDLE;
          msg_req_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          msg_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign msg_req  = msg_req_r;
  assign msg_code = msg_code_r;

endmodule

// File: doc/cmm_errman_msg_req.md
CMM_ERRMAN_MSG_REQ -- requirements
Module: cmm_errman_msg_req

Interface
REQ-001 Parameter CNT_W, default 3: width of each per-class pending-error counter.
REQ-002 Parameter FFD, default 1: register update delay for simulation only; no functional effect.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst  input  1  Reset, synchronous, active-high.
REQ-005 cor_inc  input  1  One correctable error detected this cycle.
REQ-006 nfl_inc  input  1  One non-fatal error detected this cycle.
REQ-007 ftl_inc  input  1  One fatal error detected this cycle.
REQ-008 cor_en  input  1  Correctable reporting enable; low clears and holds the cor counter at 0.
REQ-009 nfl_en  input  1  Non-fatal reporting enable; same rule as cor_en.
REQ-010 ftl_en  input  1  Fatal reporting enable; same rule as cor_en.
REQ-011 msg_ack  input  1  Transmitter accepted the current message; sampled only while msg_req=1.
REQ-012 msg_req  output  1  Error message request to the transmitter.
REQ-013 msg_code  output  2  Message class: 2'b00 correctable, 2'b01 non-fatal, 2'b11 fatal.
REQ-014 cor_cnt, nfl_cnt, ftl_cnt  output  CNT_W each  Registered pending counts.
REQ-015 cnt_ovf  output  3  Sticky saturation flags {ftl, nfl, cor}.

Function
REQ-016 Each class counter SHALL update once per clock by priority: rst -> 0; else en=0 -> 0; else inc and dec -> unchanged; else inc -> +1; else dec -> -1; else hold.
REQ-017 dec for a class SHALL be the single-cycle internal pulse generated when msg_ack=1 in state REQ and msg_code selects that class.
REQ-018 An inc at count 2^CNT_W-1 SHALL leave the count at 2^CNT_W-1 and set the matching cnt_ovf bit; the bit clears only on rst or en=0 for that class.
REQ-019 A dec at count 0 (class disabled or cleared during the request) SHALL leave the count at 0; no wrap.
REQ-020 The FSM SHALL have states IDLE, REQ and GAP.
REQ-021 IDLE: if any counter is nonzero, go to REQ and latch msg_code by fixed priority fatal > non-fatal > correctable; else stay in IDLE.
REQ-022 REQ: msg_req=1 and msg_code stays stable. msg_ack=1 moves the FSM to GAP and pulses dec for the latched class. msg_ack=0 keeps the FSM in REQ.
REQ-023 The FSM SHALL NOT withdraw a request once it is in REQ, even if the latched class is disabled or a higher-priority class becomes pending.
REQ-024 GAP: msg_req=0 for exactly one cycle, then go to IDLE unconditionally.
REQ-025 msg_req SHALL be a registered output that is 1 only in REQ; msg_code holds its last latched value outside REQ.
REQ-026 Latency: an inc at edge N is visible in the count after N; msg_req rises after edge N+1 when the FSM is in IDLE.
REQ-027 Ack at edge M: msg_req=0 and count decremented after M; the earliest next msg_req=1 is after edge M+2.
REQ-028 msg_ack while not in REQ SHALL be ignored.

Reset
REQ-029 The following SHALL clear on the first clk edge with rst=1, overriding all other inputs including msg_ack:
- FSM to IDLE
- msg_req=0
- msg_code=2'b00
- all counters=0
- cnt_ovf=3'b000
REQ-030 A reset asserted during REQ SHALL drop msg_req after that edge and SHALL NOT generate dec.

Verification
REQ-031 Single event: cor_en=1, one cor_inc pulse. Required: cor_cnt=1 next cycle; msg_req=1 with msg_code=00 one cycle later. Ack after 3 cycles: cor_cnt=0, msg_req low for 1 cycle, then the FSM stays in IDLE.
REQ-032 Priority: all enables high; cor_inc, nfl_inc and ftl_inc pulsed together. Required: messages in order 11, 01, 00, each ack decrementing only its own counter, one GAP cycle between requests.
REQ-033 Saturation, CNT_W=3: 9 consecutive ftl_inc with no ack. Required: ftl_cnt=7 and cnt_ovf[2]=1. Then ftl_en=0 for 1 cycle: ftl_cnt=0 and cnt_ovf[2]=0.
REQ-034 Simultaneous event: nfl_cnt=2 in REQ with code 01; nfl_inc and msg_ack on the same edge. Required: nfl_cnt stays 2 and the next request has code 01.
REQ-035 Disable mid-request: REQ with code 00; cor_en drops, then ack 2 cycles later. Required: msg_req held until the ack, cor_cnt stays 0 with no wrap, and no further request.
REQ-036 Reset mid-request: rst during REQ with msg_ack=1 on the same edge. Required: all outputs at reset values after the edge and counts not decremented, so they read 0.
